// File: rtl/argmin_pkg.sv
// Shared types and helpers for the streaming argmin finder.
package argmin_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StAcc  = 2'd1;
    localparam state_t StDone = 2'd2;

    // Widest value the sentinel helper covers; callers slice to their own width.
    localparam int unsigned MaxWidth = 256;

    function automatic logic [MaxWidth-1:0] all_ones();
        return '1;
    endfunction

    // Beat index held at max_n-1 once the frame runs past its nominal length.
    function automatic int unsigned sat_idx(input int unsigned cnt, input int unsigned max_n);
        return (cnt >= max_n - 1) ? max_n - 1 : cnt;
    endfunction

endpackage

// File: rtl/argmin_cmp.sv
// Compare-and-select of the running best against one incoming beat (strict-less, lowest index
// wins ties). Optional per-beat exclusion under ARGMIN_MASK_EN.
module argmin_cmp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] best,
    input  logic [IDX_W-1:0] best_idx,
    input  logic             best_empty,
    input  logic [WIDTH-1:0] beat_data,
    input  logic [IDX_W-1:0] beat_idx,
`ifdef ARGMIN_MASK_EN
    input  logic             beat_mask,
`endif
    output logic [WIDTH-1:0] nxt_best,
    output logic [IDX_W-1:0] nxt_idx,
    output logic             nxt_empty
);

    logic take;

    always_comb begin
`ifdef ARGMIN_MASK_EN
        take      = !beat_mask && (best_empty || (beat_data < best));
        nxt_empty = best_empty && beat_mask;
`else
        take      = best_empty || (beat_data < best);
        nxt_empty = 1'b0;
`endif
        nxt_best = take ? beat_data : best;
        nxt_idx  = take ? beat_idx : best_idx;
    end

endmodule

// File: rtl/argmin_stream.sv
// Streaming min/argmin over valid/ready frames delimited by in_last; result held until accepted.
// Define ARGMIN_MASK_EN to add the in_mask exclusion port and the out_none flag.
module argmin_stream
    import argmin_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX_N = 8,
    parameter int unsigned IDX_W = $clog2(MAX_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef ARGMIN_MASK_EN
    input  logic             in_mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_err
);

    // Counter saturates at MAX_N so it can flag overflow without wrapping.
    localparam int unsigned CntW = $clog2(MAX_N + 1);
    localparam logic [MaxWidth-1:0] OnesWide = all_ones();
    localparam logic [WIDTH-1:0] Ones = OnesWide[WIDTH-1:0];

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             empty_q, empty_d;

    logic             accept;
    logic             fresh;
    logic [IDX_W-1:0] beat_idx;
    logic [WIDTH-1:0] cmp_best;
    logic [IDX_W-1:0] cmp_idx;
    logic             cmp_empty;
    logic [WIDTH-1:0] nxt_best;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_empty;

    assign accept   = in_valid && ready_q;
    assign fresh    = (state_q == StIdle);
    assign beat_idx = fresh ? '0 : IDX_W'(sat_idx(32'(cnt_q), MAX_N));

    // A frame opens against an empty, all-ones best so the first eligible beat always loads.
    assign cmp_best  = fresh ? Ones : best_q;
    assign cmp_idx   = fresh ? '0 : idx_q;
`ifdef ARGMIN_MASK_EN
    assign cmp_empty = fresh ? 1'b1 : empty_q;
`else
    assign cmp_empty = fresh;
`endif

    argmin_cmp #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cmp (
        .best       (cmp_best),
        .best_idx   (cmp_idx),
        .best_empty (cmp_empty),
        .beat_data  (in_data),
        .beat_idx   (beat_idx),
`ifdef ARGMIN_MASK_EN
        .beat_mask  (in_mask),
`endif
        .nxt_best   (nxt_best),
        .nxt_idx    (nxt_idx),
        .nxt_empty  (nxt_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        err_d   = err_q;
        empty_d = empty_q;
        unique case (state_q)
            StIdle: if (accept) state_d = in_last ? StDone : StAcc;
            StAcc:  if (accept && in_last) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            best_d  = nxt_best;
            idx_d   = nxt_idx;
            empty_d = nxt_empty;
            if (fresh) begin
                cnt_d = CntW'(1);
                err_d = 1'b0;
            end else begin
                cnt_d = (cnt_q == CntW'(MAX_N)) ? cnt_q : cnt_q + 1'b1;
                err_d = err_q || (cnt_q == CntW'(MAX_N));
            end
        end
        ready_d = (state_d != StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            empty_q <= empty_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == StDone);
    assign out_min   = best_q;
    assign out_idx   = idx_q;
    assign out_err   = err_q;
`ifdef ARGMIN_MASK_EN
    assign out_none  = empty_q;
`else
    assign out_none  = 1'b0;
`endif

endmodule

// File: tb/tb_argmin_stream.sv
// Directed bench for argmin_stream: hand-computed frames, handshake, overflow and reset cases.
module tb_argmin_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_mask = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_min;
    logic [2:0] out_idx;
    logic       out_none;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    argmin_stream #(
        .WIDTH (8),
        .MAX_N (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef ARGMIN_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [7:0] d, input logic last, input logic m);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_mask  = m;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mask  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] mn, input logic [2:0] ix,
                                 input logic none, input logic err);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_min"}, 32'(out_min), 32'(mn));
        check({tag, "_idx"}, 32'(out_idx), 32'(ix));
        check({tag, "_none"}, 32'(out_none), 32'(none));
        check({tag, "_err"}, 32'(out_err), 32'(err));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ovf [10];
        ovf = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd15, 8'd12, 8'd10, 8'd9, 8'd5, 8'd1};

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_min", 32'(out_min), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_none", 32'(out_none), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_still_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Ties: earliest 3 wins
        send(8'd7, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        send(8'd9, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        check("f1_not_yet_valid", 32'(out_valid), 32'd0);
        send(8'd5, 1'b1, 1'b0);
        expect_result("f1", 8'd3, 3'd1, 1'b0, 1'b0);

        // Single beat, then hold out_ready low with in_valid high
        send(8'd200, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd77;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_min", 32'(out_min), 32'd200);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("single", 8'd200, 3'd0, 1'b0, 1'b0);

        // 10-beat frame on MAX_N=8: index saturates at 7, err flagged
        for (int i = 0; i < 10; i++) send(ovf[i], (i == 9), 1'b0);
        expect_result("ovf", 8'd1, 3'd7, 1'b0, 1'b1);

        // Asynchronous reset mid-frame
        send(8'd9, 1'b0, 1'b0);
        send(8'd8, 1'b0, 1'b0);
        send(8'd7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_min", 32'(out_min), 32'd0);
        check("mid_rst_idx", 32'(out_idx), 32'd0);
        check("mid_rst_err", 32'(out_err), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_up", 32'(in_ready), 32'd1);
        send(8'd4, 1'b0, 1'b0);
        send(8'd2, 1'b1, 1'b0);
        expect_result("post_rst", 8'd2, 3'd1, 1'b0, 1'b0);

`ifdef ARGMIN_MASK_EN
        send(8'd1, 1'b0, 1'b1);
        send(8'd6, 1'b0, 1'b0);
        send(8'd4, 1'b1, 1'b0);
        expect_result("mask", 8'd4, 3'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b1);
        send(8'd2, 1'b0, 1'b1);
        send(8'd1, 1'b1, 1'b1);
        expect_result("all_masked", 8'hFF, 3'd0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/argmin_stream.md
# argmin_stream

Sequential, parametrised minimum/argmin finder. Candidate values arrive as a valid/ready stream framed by `in_last`. The block returns the minimum value, the index of its first occurrence and status flags through a held output handshake. It replaces the fixed 8-input combinational min compare in the move-evaluation path. It supports arbitrary value width and frame length up to `MAX_N`, a deterministic lowest-index tie rule and an optional per-candidate exclusion mask for blocked moves.

## Interface
- `WIDTH`, 8: candidate/result bit width, ≥1.
- `MAX_N`, 8: maximum candidates per frame, ≥2.
- `IDX_W`, `$clog2(MAX_N)`: derived index width; not overridden by users.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: candidate beat valid.
- `in_ready` out 1: block accepts a beat; registered.
- `in_data` in WIDTH: candidate value, unsigned.
- `in_last` in 1: beat is the final candidate of the frame.
- `in_mask` in 1: exclude this beat from selection; present only with `ARGMIN_MASK_EN`.
- `out_valid` out 1: result valid, held until accepted.
- `out_ready` in 1: consumer accepts result.
- `out_min` out WIDTH: minimum unmasked value of the frame.
- `out_idx` out IDX_W: zero-based beat index of `out_min`.
- `out_none` out 1: every beat of the frame was masked.
- `out_err` out 1: the frame contained more than `MAX_N` beats.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- The beat counter starts at 0 per frame and increments per accepted beat.
- States:
  - IDLE: `in_ready`=1, no frame open. An accepted beat opens the frame and loads best := beat. If `in_last`, go to DONE; otherwise go to ACC.
  - ACC: `in_ready`=1. Each accepted beat replaces best only if unmasked and strictly less than best, or if best is still empty. An accepted beat with `in_last` goes to DONE.
  - DONE: `in_ready`=0, `out_valid`=1, outputs stable. When `out_ready`=1, go to IDLE.
- Ties: the earliest beat wins. Equal later values never replace best.
- Comparison is unsigned over the full WIDTH.
- Frames longer than `MAX_N`:
  - Extra beats are still accepted and compared.
  - Their recorded index saturates at `MAX_N-1`.
  - `out_err`=1 for that frame.
  - The counter never wraps.
- Single-beat frame: `out_min`=beat, `out_idx`=0.
- `in_valid` low mid-frame simply stalls ACC; there is no timeout.
- `in_data`, `in_mask` and `in_last` are ignored when `in_valid`=0.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0; it rises on the first `clk` edge after `rst` deasserts.
  - `out_valid`=0, `out_min`=0, `out_idx`=0, `out_none`=0, `out_err`=0.
- Reset mid-frame or in DONE discards the partial frame or pending result immediately (asynchronous).
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat. Results are visible the cycle after the last beat. `in_ready` falls on the same edge.
- Result handshake: the `out_valid`&&`out_ready` edge returns to IDLE. `in_ready` rises on that edge, so the next beat can be accepted one cycle later.
- Throughput: one frame per N+1 cycles with continuous stimulus.
- Outputs are registered. There is no combinational in→out path. `out_ready` affects only the state register.

## Configuration
- `ARGMIN_MASK_EN` defined:
  - The `in_mask` port exists.
  - Masked beats advance the index but never become best.
  - An all-masked frame yields `out_none`=1, `out_min`=all ones, `out_idx`=0.
- `ARGMIN_MASK_EN` undefined:
  - No `in_mask` port; every beat is eligible.
  - `out_none` is tied to 0.
  - Area drops by the mask and empty-best logic.

## Structure
- The shared package `argmin_pkg` holds:
  - the state encoding typedef (IDLE/ACC/DONE);
  - the all-ones sentinel helper;
  - the index saturation function.
- The natural sub-module is `argmin_cmp`: combinational compare-and-select of (best, best_idx, best_empty) against the incoming beat. It applies the strict-less rule and the mask. Instantiate it once.
- The counter, FSM and output registers live in the top module.

## Test plan
- Frame 7,3,9,3,5 (last on 5) -> `out_min`=3, `out_idx`=1, `out_err`=0; `out_valid` the cycle after the 5 is accepted.
- Single beat 200 with `in_last` -> `out_min`=200, `out_idx`=0; `in_ready`=0 until `out_ready`.
- Hold `out_ready`=0 for 4 cycles with `in_valid` high -> no beat accepted, outputs stable, then IDLE one cycle after `out_ready`=1.
- MAX_N=8, 10-beat frame with minimum 1 at beat 9 -> `out_min`=1, `out_idx`=7, `out_err`=1.
- `rst` pulsed after 3 beats of a frame -> all outputs 0, `in_ready`=0, then 1. A new frame 4,2 gives min 2, idx 1.
- `ARGMIN_MASK_EN`: frame 1(masked),6,4 -> min 4, idx 2. Fully masked 3-beat frame -> `out_none`=1, `out_min`=0xFF.
